// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state encoding.
// The receiver imports this package too, so both ends derive the same bit period.
package uart_pkg;

    localparam int CLK_FREQ   = 100_000_000;
    localparam int BAUD_RATE  = 9600;
    localparam int OVERSAMPLE = 4;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    // Truncate to a whole number of oversample ticks so TX and RX bit periods match exactly.
    function automatic int calc_bit_clks(input int clk_freq, input int baud, input int os);
        return (clk_freq / (baud * os)) * os;
    endfunction

    localparam int BIT_CLKS = calc_bit_clks(CLK_FREQ, BAUD_RATE, OVERSAMPLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count and fall-through head data.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed from a byte FIFO; TxD comes straight from a flop.
// Back-to-back frames are chained from the last stop-bit clock with no idle gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = uart_pkg::CLK_FREQ,
    parameter int BAUD_RATE  = uart_pkg::BAUD_RATE,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            TxD,
    output logic                            busy,
    output logic                            tx_done,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    import uart_pkg::tx_state_t;
    import uart_pkg::IDLE;
    import uart_pkg::START;
    import uart_pkg::DATA;
    import uart_pkg::STOP;
    import uart_pkg::DATA_BITS;
    import uart_pkg::calc_bit_clks;

    localparam int BIT_CLKS = calc_bit_clks(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW       = $clog2(BIT_CLKS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CLKS - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(DATA_BITS - 1);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [TW-1:0] r_bit_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_idx_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_txd;
    logic        w_txd_nxt;
    logic        w_bit_end;
    logic        w_pop;
    logic        w_push;
    logic        w_tx_done;
    logic [7:0]  w_fifo_dout;
    logic        w_full;
    logic        w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;

    assign tx_ready = !w_full && !reset;
    assign w_push   = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (tx_data),
        .dout  (w_fifo_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_bit_end = (r_bit_timer == TIMER_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_bit_timer + 1'b1;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_tx_done   = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_timer_nxt = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_timer_nxt = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_tx_done   = 1'b1;
                    w_timer_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level is decided from the next state so the flop output changes exactly on bit boundaries.
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_txd_nxt = 1'b0;
            DATA:    w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_timer <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_txd       <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_timer <= w_timer_nxt;
            r_bit_idx   <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_txd       <= w_txd_nxt;
        end
    end

    assign TxD        = r_txd;
    assign busy       = (r_state != IDLE);
    assign tx_done    = w_tx_done;
    assign fifo_count = w_count;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART 8N1 transmitter with an input byte FIFO. It serialises key bytes produced by the chaos key generator onto TxD. It is the upstream stage of the UART receiver and drives that receiver's RxD line. Its bit timing matches the receiver's 4x-oversampled baud counter exactly, so a board or bench loopback needs no tolerance.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits per second
OVERSAMPLE, 4, receiver oversample factor; used only to derive bit period
FIFO_DEPTH, 16, FIFO entries; must be a power of 2
BIT_CLKS, (CLK_FREQ/(BAUD_RATE*OVERSAMPLE))*OVERSAMPLE = 10416, clocks per bit (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
tx_data  in  8  byte to send
tx_valid  in  1  tx_data is valid
tx_ready  out  1  FIFO can accept; a transfer occurs on any edge where tx_valid && tx_ready
TxD  out  1  serial line, idle high, registered
busy  out  1  frame in progress (state != IDLE)
tx_done  out  1  one-cycle pulse on the last clock of each stop bit
fifo_count  out  5  bytes currently held in the FIFO (0..16)

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - Outputs after reset: TxD=1, busy=0, tx_done=0, fifo_count=0.
  - tx_ready=0 while reset is high and 1 on the first cycle after release.
  - FIFO pointers are cleared. Contents are don't-care.
- tx_ready = (fifo_count != FIFO_DEPTH) && !reset. It is combinational from registered count.
- FIFO:
  - Push on tx_valid && tx_ready.
  - Pop is issued only by the FSM, and only when fifo_count != 0.
  - Simultaneous push and pop leaves the count unchanged; data order is preserved.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is one bit wider.
  - Push while full is impossible because ready is low; tx_valid is simply ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TxD=1. If fifo_count != 0: pop head into shift_reg, clear bit_timer, go to START.
  - START: TxD=0 for BIT_CLKS clocks.
  - DATA: TxD=shift_reg[0]. Every BIT_CLKS clocks, shift right and increment bit_idx. After 8 bits, go to STOP. Order is LSB first.
  - STOP: TxD=1 for BIT_CLKS clocks. tx_done pulses on its final clock. On that clock:
    - if fifo_count != 0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*BIT_CLKS = 104160 clocks.
  - bit_timer counts 0..BIT_CLKS-1 and clears on wrap and on every state entry.
  - The first data bit is on TxD exactly BIT_CLKS clocks after TxD falls.
- Latency: a byte accepted into an empty FIFO while IDLE on edge E0 is popped on edge E1. TxD goes low after E1.
- TxD changes only on bit boundaries. It is glitch-free because it is driven from a flop.
- Reset mid-frame:
  - TxD=1 on the next edge and the frame is truncated.
  - The FIFO is flushed.
  - The next accepted byte produces a clean full frame.
- Back-to-back frames: with a continuously non-empty FIFO, consecutive start-bit falling edges are exactly 104160 clocks apart.

Decomposition:
- Package uart_pkg:
  - CLK_FREQ, BAUD_RATE, OVERSAMPLE;
  - derived BIT_CLKS;
  - FRAME_BITS=10, DATA_BITS=8;
  - tx_state_t enum (IDLE, START, DATA, STOP).
- The receiver imports the same package.
- Sub-module sync_fifo:
  - parameters WIDTH=8, DEPTH;
  - ports push/pop/din/dout/count/full/empty;
  - registered count, fall-through head data.
- The FSM, bit timer and shift register stay in uart_tx_fifo.

Test Plan:
1. Reset, then push 0xA5 once. TxD sampled at each bit centre reads 0,1,0,1,0,0,1,0,1,1. busy is high for 104160 clocks. tx_done pulses once. Loopback into the receiver yields RxData=0xA5.
2. Push 0x00..0x10 (17 bytes) on consecutive cycles. The first byte pops after one cycle, so fifo_count reaches 16 and tx_ready drops after the 17th accept. 17 frames go out contiguously in 17*104160 clocks. Received sequence is 0x00..0x10 in order.
3. FIFO full, tx_valid held high with 0x3C. Not accepted until the pop at the end of the current frame's stop bit, then accepted on the next edge. 0x3C is transmitted last; no byte is lost or duplicated.
4. Assert reset during data bit 3 of 0xFF. TxD=1 on the next edge, fifo_count=0, busy=0. A following push of 0x81 produces a clean frame that the receiver decodes as 0x81.
5. fifo_count=1 mid-frame, push on the same edge as the STOP-end pop. fifo_count stays 1. The next frame starts with no idle cycle.
6. Measure from the TxD falling edge to each bit transition. Transitions occur at exact multiples of 10416 clocks; stop bit ends at 104160.
